// File: rtl/reg_file_rename.sv
// Architectural register file with per-register rename status (busy + producing ROB slot).
// Commit writes values and retires the rename; issue renames rd; rollback drops all renames.
module reg_file_rename #(
  parameter int REG_NUM   = 32,
  parameter int DATA_W    = 32,
  parameter int ROB_POS_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 rollback,
  input  logic                 reg_write,
  input  logic [4:0]           reg_rd,
  input  logic [DATA_W-1:0]    reg_val,
  input  logic [ROB_POS_W-1:0] commit_rob_pos,
  input  logic                 issue,
  input  logic [4:0]           issue_rd,
  input  logic [ROB_POS_W-1:0] issue_rob_pos,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  output logic [DATA_W-1:0]    rs1_val,
  output logic [DATA_W-1:0]    rs2_val,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic [ROB_POS_W-1:0] rs1_tag,
  output logic [ROB_POS_W-1:0] rs2_tag
);

  typedef struct packed {
    logic [DATA_W-1:0]    val;
    logic                 busy;
    logic [ROB_POS_W-1:0] tag;
  } rd_rsp_t;

  logic [REG_NUM-1:0][DATA_W-1:0]    val_q, val_d;
  logic [REG_NUM-1:0]                busy_q, busy_d;
  logic [REG_NUM-1:0][ROB_POS_W-1:0] tag_q, tag_d;

  always_comb begin
    val_d  = val_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    if (rst) begin
      val_d  = '0;
      busy_d = '0;
      tag_d  = '0;
    end else if (rdy) begin
      if (reg_write && reg_rd != 5'd0) begin
        val_d[reg_rd] = reg_val;
        // Only the youngest producer may retire the rename.
        if (busy_q[reg_rd] && tag_q[reg_rd] == commit_rob_pos)
          busy_d[reg_rd] = 1'b0;
      end
      if (issue && issue_rd != 5'd0 && !rollback) begin
        busy_d[issue_rd] = 1'b1;
        tag_d[issue_rd]  = issue_rob_pos;
      end
      if (rollback)
        busy_d = '0;
    end
    val_d[0]  = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    val_q  <= val_d;
    busy_q <= busy_d;
    tag_q  <= tag_d;
  end

  // Reads use pre-issue state plus a bypass of the retiring commit.
  function automatic rd_rsp_t read_port(input logic [4:0] rs);
    rd_rsp_t r;
    r = '0;
    if (rs != 5'd0) begin
      r.val  = val_q[rs];
      r.busy = busy_q[rs];
      r.tag  = tag_q[rs];
      if (reg_write && reg_rd == rs && busy_q[rs] && tag_q[rs] == commit_rob_pos) begin
        r.val  = reg_val;
        r.busy = 1'b0;
      end
    end
    return r;
  endfunction

  rd_rsp_t rsp1, rsp2;

  always_comb begin
    rsp1     = read_port(rs1);
    rsp2     = read_port(rs2);
    rs1_val  = rsp1.val;
    rs1_busy = rsp1.busy;
    rs1_tag  = rsp1.tag;
    rs2_val  = rsp2.val;
    rs2_busy = rsp2.busy;
    rs2_tag  = rsp2.tag;
  end

endmodule

// File: tb/tb_reg_file_rename.sv
// Bench for reg_file_rename: array-based reference model checked every cycle, plus directed literals.
module tb_reg_file_rename;
  localparam int DW = 32;
  localparam int PW = 4;

  logic clk = 0;
  logic rst, rdy, rollback, reg_write, issue;
  logic [4:0] reg_rd, issue_rd, rs1, rs2;
  logic [DW-1:0] reg_val;
  logic [PW-1:0] commit_rob_pos, issue_rob_pos;
  logic [DW-1:0] rs1_val, rs2_val;
  logic rs1_busy, rs2_busy;
  logic [PW-1:0] rs1_tag, rs2_tag;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  logic [DW-1:0] m_val [32];
  bit            m_busy[32];
  logic [PW-1:0] m_tag [32];

  always #5 clk = ~clk;

  reg_file_rename dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .reg_write(reg_write), .reg_rd(reg_rd), .reg_val(reg_val), .commit_rob_pos(commit_rob_pos),
    .issue(issue), .issue_rd(issue_rd), .issue_rob_pos(issue_rob_pos),
    .rs1(rs1), .rs2(rs2),
    .rs1_val(rs1_val), .rs2_val(rs2_val),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rs1_tag(rs1_tag), .rs2_tag(rs2_tag)
  );

  // Reference: straight from the architectural rules.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin m_val[i] = 0; m_busy[i] = 0; m_tag[i] = 0; end
    end else if (rdy) begin
      if (reg_write && reg_rd != 0) begin
        m_val[reg_rd] = reg_val;
        if (m_busy[reg_rd] && m_tag[reg_rd] == commit_rob_pos) m_busy[reg_rd] = 0;
      end
      if (issue && issue_rd != 0 && !rollback) begin
        m_busy[issue_rd] = 1;
        m_tag[issue_rd]  = issue_rob_pos;
      end
      if (rollback) for (int i = 0; i < 32; i++) m_busy[i] = 0;
    end
  end

  task automatic exp_read(input logic [4:0] rs, output logic [DW-1:0] v, output bit b,
                          output logic [PW-1:0] t);
    v = 0; b = 0; t = 0;
    if (rs != 0) begin
      v = m_val[rs]; b = m_busy[rs]; t = m_tag[rs];
      if (reg_write && reg_rd == rs && m_busy[rs] && m_tag[rs] == commit_rob_pos) begin
        v = reg_val; b = 0;
      end
    end
  endtask

  task automatic cmp(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [DW-1:0] v; bit b; logic [PW-1:0] t;
    if (chk_en) begin
      exp_read(rs1, v, b, t);
      cmp("model_rs1_val", rs1_val, v);
      cmp("model_rs1_busy", {31'd0, rs1_busy}, {31'd0, b});
      if (b || rs1 == 0) cmp("model_rs1_tag", {28'd0, rs1_tag}, {28'd0, t});
      exp_read(rs2, v, b, t);
      cmp("model_rs2_val", rs2_val, v);
      cmp("model_rs2_busy", {31'd0, rs2_busy}, {31'd0, b});
      if (b || rs2 == 0) cmp("model_rs2_tag", {28'd0, rs2_tag}, {28'd0, t});
    end
  end

  task automatic idle();
    rst = 0; rdy = 1; rollback = 0; reg_write = 0; reg_rd = 0; reg_val = 0;
    commit_rob_pos = 0; issue = 0; issue_rd = 0; issue_rob_pos = 0; rs1 = 0; rs2 = 0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic lit1(input string n, input logic [DW-1:0] v, input bit b);
    #1;
    cmp({n, "_val"}, rs1_val, v);
    cmp({n, "_busy"}, {31'd0, rs1_busy}, {31'd0, b});
  endtask

  initial begin
    idle(); rst = 1;
    cyc(); cyc();
    // Reset state
    idle(); rs1 = 5; rs2 = 0; chk_en = 1;
    lit1("reset_rs1", 0, 0);
    cmp("reset_rs1_tag", {28'd0, rs1_tag}, 0);
    cmp("reset_rs2_val", rs2_val, 0);
    cmp("reset_rs2_busy", {31'd0, rs2_busy}, 0);
    cmp("reset_rs2_tag", {28'd0, rs2_tag}, 0);
    cyc();
    // Issue then matching commit with bypass
    idle(); issue = 1; issue_rd = 3; issue_rob_pos = 7; rs1 = 3;
    lit1("issue_self_read", 0, 0);
    cyc();
    idle(); reg_write = 1; reg_rd = 3; commit_rob_pos = 7; reg_val = 32'h1234; rs1 = 3;
    lit1("bypass_x3", 32'h1234, 0);
    cyc();
    idle(); rs1 = 3; lit1("state_x3", 32'h1234, 0);
    cyc();
    // Stale commit keeps newer rename
    idle(); issue = 1; issue_rd = 4; issue_rob_pos = 2; cyc();
    idle(); issue = 1; issue_rd = 4; issue_rob_pos = 9; cyc();
    idle(); reg_write = 1; reg_rd = 4; commit_rob_pos = 2; reg_val = 32'hAA; rs1 = 4;
    lit1("stale_commit_x4", 0, 1);
    cyc();
    idle(); rs1 = 4; lit1("after_stale_x4", 32'hAA, 1);
    cmp("after_stale_x4_tag", {28'd0, rs1_tag}, 9);
    rollback = 1; cyc();
    idle(); rs1 = 4; lit1("rollback_x4", 32'hAA, 0);
    cyc();
    // Commit and issue same register same cycle
    idle(); issue = 1; issue_rd = 6; issue_rob_pos = 1; cyc();
    idle(); reg_write = 1; reg_rd = 6; commit_rob_pos = 1; reg_val = 32'h5555;
    issue = 1; issue_rd = 6; issue_rob_pos = 5; rs1 = 6;
    lit1("commit_issue_x6", 32'h5555, 0);
    cyc();
    idle(); rs1 = 6; lit1("reissued_x6", 32'h5555, 1);
    cmp("reissued_x6_tag", {28'd0, rs1_tag}, 5);
    cyc();
    // x0 writes discarded
    idle(); issue = 1; issue_rd = 0; issue_rob_pos = 3; reg_write = 1; reg_rd = 0; reg_val = 32'hFF;
    cyc();
    idle(); rs2 = 0; lit1("x0", 0, 0);
    cmp("x0_rs2_val", rs2_val, 0);
    cyc();
    // rdy low holds state
    idle(); issue = 1; issue_rd = 8; issue_rob_pos = 11; cyc();
    idle(); rdy = 0; reg_write = 1; reg_rd = 8; commit_rob_pos = 11; reg_val = 32'h88;
    issue = 1; issue_rd = 9; issue_rob_pos = 12; cyc();
    idle(); rs1 = 8; rs2 = 9; lit1("hold_x8", 0, 1);
    cmp("hold_x8_tag", {28'd0, rs1_tag}, 11);
    cmp("hold_x9_busy", {31'd0, rs2_busy}, 0);
    cyc();
    // rs2 bypass, then rollback suppresses issue
    idle(); reg_write = 1; reg_rd = 8; commit_rob_pos = 11; reg_val = 32'h88; rs2 = 8;
    #1; cmp("bypass_rs2_val", rs2_val, 32'h88);
    cmp("bypass_rs2_busy", {31'd0, rs2_busy}, 0);
    cyc();
    idle(); rollback = 1; issue = 1; issue_rd = 2; issue_rob_pos = 3; cyc();
    idle(); rs1 = 2; lit1("rollback_issue_x2", 0, 0);
    cyc();
    // Mid-stream reset
    idle(); issue = 1; issue_rd = 10; issue_rob_pos = 6; cyc();
    idle(); rst = 1; cyc();
    idle(); rs1 = 10; rs2 = 3; lit1("midreset_x10", 0, 0);
    cmp("midreset_x3_val", rs2_val, 0);
    cyc();
    // Mixed traffic, model-checked only
    for (int i = 0; i < 300; i++) begin
      idle();
      issue = ($urandom_range(0, 2) != 0); issue_rd = 5'($urandom_range(0, 7));
      issue_rob_pos = 4'($urandom_range(0, 15));
      reg_write = ($urandom_range(0, 1) != 0); reg_rd = 5'($urandom_range(0, 7));
      commit_rob_pos = (reg_rd != 0 && m_busy[reg_rd] && $urandom_range(0, 2) != 0) ?
                       m_tag[reg_rd] : 4'($urandom_range(0, 15));
      reg_val = $urandom;
      rollback = ($urandom_range(0, 19) == 0);
      rdy = ($urandom_range(0, 9) != 0);
      rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
      cyc();
    end
    idle(); cyc(); cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
